// File: rtl/control_sequencer_if.sv
// Memory bus between the control sequencer (master) and its memory (slave).
interface control_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/control_sequencer.sv
// Accumulator-machine control sequencer: fetches 8-bit instructions over a
// ready-handshaked memory bus, drives an external combinational ALU and
// keeps PC, IR, AC, DR and the zero flag.
module control_sequencer #(
    parameter int          ADDR_W   = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    control_sequencer_if.master       mem_bus,
    output logic [7:0]                alu_ac,
    output logic [7:0]                alu_dr,
    output logic [2:0]                alu_sel,
    input  logic [7:0]                alu_result,
    output logic [ADDR_W-1:0]         pc,
    output logic                      z,
    output logic                      halted
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, READ, EXEC, WRITE, HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_XOR = 3'b010,
        OP_SHL = 3'b011,
        OP_LDA = 3'b100,
        OP_STA = 3'b101,
        OP_CMA = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        ir;
    logic [7:0]        ac;
    logic [7:0]        dr;
    opcode_t           opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = opcode_t'(ir[7:5]);
    assign operand = ir[ADDR_W-1:0];

    assign alu_ac            = ac;
    assign alu_dr            = dr;
    assign mem_bus.mem_wdata = ac;
    assign halted            = (state == HALT);

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus/ALU controls; controls depend on registered state only.
    always_comb begin
        state_next       = state;
        mem_bus.mem_req  = 1'b0;
        mem_bus.mem_we   = 1'b0;
        mem_bus.mem_addr = operand;
        alu_sel          = 3'b111;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_bus.mem_req  = 1'b1;
                mem_bus.mem_addr = pc;
                if (mem_bus.mem_ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_XOR, OP_LDA: state_next = READ;
                    OP_SHL, OP_CMA:                 state_next = EXEC;
                    OP_STA:                         state_next = WRITE;
                    OP_HLT:                         state_next = HALT;
                    default:                        state_next = HALT;
                endcase
            end
            READ: begin
                mem_bus.mem_req = 1'b1;
                if (mem_bus.mem_ready) begin
                    state_next = (opcode == OP_LDA) ? FETCH : EXEC;
                end
            end
            EXEC: begin
                alu_sel    = ir[7:5];
                state_next = FETCH;
            end
            WRITE: begin
                mem_bus.mem_req = 1'b1;
                mem_bus.mem_we  = 1'b1;
                if (mem_bus.mem_ready) begin
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers; nothing moves while a bus phase waits on mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
            ir <= '0;
            ac <= '0;
            dr <= '0;
            z  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_bus.mem_ready) begin
                        ir <= mem_bus.mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                READ: begin
                    if (mem_bus.mem_ready) begin
                        if (opcode == OP_LDA) begin
                            ac <= mem_bus.mem_rdata;
                            z  <= (mem_bus.mem_rdata == 8'h00);
                        end else begin
                            dr <= mem_bus.mem_rdata;
                        end
                    end
                end
                EXEC: begin
                    ac <= alu_result;
                    z  <= (alu_result == 8'h00);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, giving the memory address width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 clk  input  1  Single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset.
REQ-005 start  input  1  Leaves IDLE when sampled high.
REQ-006 mem_req  output  1  Memory request is valid.
REQ-007 mem_we  output  1  1 selects a write, 0 selects a read; valid only while mem_req=1.
REQ-008 mem_addr  output  ADDR_W  Memory address.
REQ-009 mem_wdata  output  8  Write data, equal to AC.
REQ-010 mem_ready  input  1  Memory completes the request in the current cycle.
REQ-011 mem_rdata  input  8  Read data, valid when mem_req=1 and mem_ready=1.
REQ-012 alu_ac  output  8  ALU operand A, equal to the AC register.
REQ-013 alu_dr  output  8  ALU operand B, equal to the DR register.
REQ-014 alu_sel  output  3  ALU operation select.
REQ-015 alu_result  input  8  Combinational ALU result.
REQ-016 pc  output  ADDR_W  Current program counter.
REQ-017 z  output  1  Set when the last AC write was zero.
REQ-018 halted  output  1  High in the HALT state.

Function
REQ-019 The instruction word SHALL be 8 bits: opcode = IR[7:5], operand address = IR[ADDR_W-1:0].
- Requires ADDR_W <= 5.
- Any IR bits between ADDR_W and bit 4 SHALL be ignored.
REQ-020 Opcodes SHALL be:
- 000 ADD: AC <= AC+M[a]
- 001 SUB: AC <= AC-M[a]
- 010 XOR: AC <= AC^M[a]
- 011 SHL: AC <= AC+AC
- 100 LDA: AC <= M[a]
- 101 STA: M[a] <= AC
- 110 CMA: AC <= ~AC
- 111 HLT
REQ-021 States SHALL be IDLE, FETCH, DECODE, READ, EXEC, WRITE and HALT.
REQ-022 IDLE: the block SHALL go to FETCH when start=1, and otherwise remain in IDLE.
REQ-023 FETCH: the block SHALL drive mem_req=1, mem_we=0 and mem_addr=pc.
- On mem_ready=1: IR <= mem_rdata, pc <= pc+1 modulo 2^ADDR_W, next state DECODE.
REQ-024 DECODE (one cycle):
- ADD, SUB, XOR, LDA go to READ.
- SHL, CMA go to EXEC.
- STA goes to WRITE.
- HLT goes to HALT.
REQ-025 READ: the block SHALL drive mem_req=1, mem_we=0 and mem_addr=IR address.
- On mem_ready=1, ADD/SUB/XOR SHALL load DR <= mem_rdata and go to EXEC.
- On mem_ready=1, LDA SHALL load AC <= mem_rdata and go to FETCH.
REQ-026 EXEC (one cycle): the block SHALL drive alu_sel=opcode, load AC <= alu_result, and go to FETCH.
REQ-027 WRITE: the block SHALL drive mem_req=1, mem_we=1, mem_addr=IR address and mem_wdata=AC.
- On mem_ready=1, next state FETCH.
REQ-028 HALT: the block SHALL hold halted=1 and remain in HALT until rst; start SHALL be ignored.
REQ-029 Outside EXEC, alu_sel SHALL equal 3'b111.
REQ-030 Outside FETCH, READ and WRITE, mem_req SHALL be 0.
REQ-031 While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata SHALL be held stable and no register SHALL change.
REQ-032 mem_req, mem_we, mem_addr, mem_wdata and alu_sel SHALL be decoded from registered state only.
- They SHALL have no combinational dependence on mem_ready, mem_rdata or alu_result.
REQ-033 On every AC write, z SHALL be set to (new AC == 0); otherwise z SHALL hold.
REQ-034 Arithmetic SHALL be 8-bit modulo 256; carry out is discarded.
REQ-035 With zero-wait memory (mem_ready=1 every cycle), instruction latency measured from the first FETCH cycle SHALL be:
- 4 cycles for ADD, SUB, XOR
- 3 cycles for SHL, CMA, LDA, STA
- Each cycle of mem_ready=0 SHALL add one cycle.
REQ-036 pc SHALL wrap from 2^ADDR_W-1 to 0 without any flag or stall.

Reset
REQ-037 When rst=1 at a rising clk edge, the block SHALL set:
- state = IDLE, pc = RESET_PC
- AC = 0, DR = 0, IR = 0, z = 0
REQ-038 Reset SHALL take priority over start, mem_ready and every state transition.
REQ-039 Reset mid-transaction SHALL drop mem_req to 0 from the cycle after the reset edge.
- Any pending memory transfer is abandoned with no write retried.
REQ-040 halted SHALL be 0 from the cycle after the reset edge.

Verification
REQ-041 Zero-wait program check:
- Stimulus: M[0..3] = 0x9A (LDA 26), 0x1B (ADD 27), 0xBC (STA 28), 0xE0 (HLT); M[26]=0x05, M[27]=0xFB; start pulse.
- Response: M[28]=0x00, z=1, pc=4, halted=1 after 3+4+3+3 cycles (HLT: FETCH, DECODE, then HALT).
REQ-042 Opcode coverage:
- Stimulus: with AC=0x81, execute SHL, then CMA, then XOR with M[a]=0xFF.
- Response: alu_sel 011, 110, 010 during the respective EXEC cycles; AC = 0x02, then 0xFD, then 0x02.
REQ-043 Wait states:
- Stimulus: hold mem_ready=0 for 3 cycles during FETCH and for 2 cycles during WRITE.
- Response: mem_addr and mem_wdata are stable throughout; the instruction takes exactly 5 extra cycles; the write occurs exactly once.
REQ-044 PC wrap:
- Stimulus: RESET_PC=31, M[31]=0x60 (SHL), M[0]=0xE0.
- Response: pc goes 31 -> 0 -> 1, then halted=1.
REQ-045 Reset in READ:
- Stimulus: assert rst for 1 cycle while in READ with mem_ready=0.
- Response: next cycle mem_req=0, AC=0, pc=RESET_PC, state IDLE; no fetch until start.
REQ-046 SUB wrap:
- Stimulus: AC=0x03, SUB with M[a]=0x05.
- Response: AC=0xFE, z=0.
